// File: rtl/sd_metadata_loader.sv
// Drives sd_controller through NUM_SECTORS consecutive sector reads and packs the
// byte stream into big-endian 32-bit words for the metadata store.
module sd_metadata_loader #(
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int          NUM_SECTORS = 8,
    parameter int          TIMEOUT     = 2_000_000,
    localparam int         AW          = $clog2(NUM_SECTORS * 128)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          sd_ready,
    input  logic          sd_byte_available,
    input  logic [7:0]    sd_dout,
    output logic          sd_rd,
    output logic [31:0]   sd_address,
    output logic          write_en,
    output logic [31:0]   write_word,
    output logic [AW-1:0] write_addr,
    output logic          busy,
    output logic          loaded,
    output logic          error
);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    SEC_LAST = 8'(NUM_SECTORS - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_READY, ISSUE, READ, SECTOR_END, DONE, ERROR
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] tmo_cnt;
    logic [8:0]    byte_cnt;
    logic [7:0]    sector_cnt;
    logic [23:0]   byte_buf;
    logic          avail_q;
    logic          capture, restart, waiting, timed_out;

    assign busy   = !(state inside {IDLE, DONE, ERROR});
    assign loaded = (state == DONE);
    assign error  = (state == ERROR);

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        restart    = 1'b0;
        waiting    = state inside {WAIT_READY, ISSUE, READ, SECTOR_END};
        timed_out  = waiting && (tmo_cnt >= TMO_LAST);
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    restart    = 1'b1;
                    state_next = WAIT_READY;
                end
            end
            WAIT_READY: if (sd_ready) state_next = ISSUE;
            ISSUE:      if (!sd_ready) state_next = READ;
            READ: begin
                // a byte is the rising edge of the level, however long it is held
                capture = sd_byte_available && !avail_q;
                if (capture && byte_cnt == 9'd511) state_next = SECTOR_END;
            end
            SECTOR_END: begin
                if (sd_ready) state_next = (sector_cnt == SEC_LAST) ? DONE : ISSUE;
            end
            default: state_next = IDLE;
        endcase
        // a capture restarts the timer, so it wins over an expiring count
        if (timed_out && !capture) state_next = ERROR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_rd      <= 1'b0;
            sd_address <= BASE_ADR;
            write_en   <= 1'b0;
            write_word <= '0;
            write_addr <= '0;
            tmo_cnt    <= '0;
            byte_cnt   <= '0;
            sector_cnt <= '0;
            byte_buf   <= '0;
            avail_q    <= 1'b0;
        end else begin
            avail_q  <= sd_byte_available;
            write_en <= 1'b0;
            if (write_en) write_addr <= write_addr + 1'b1;

            if (!waiting || state_next != state || capture) tmo_cnt <= '0;
            else                                             tmo_cnt <= tmo_cnt + 1'b1;

            if (restart) begin
                sector_cnt <= '0;
                sd_address <= BASE_ADR;
                write_addr <= '0;
            end

            if (state == WAIT_READY && state_next == ISSUE) sd_rd <= 1'b1;

            if (state == ISSUE && state_next == READ) begin
                sd_rd    <= 1'b0;
                byte_cnt <= '0;
            end

            if (capture) begin
                byte_cnt <= byte_cnt + 1'b1;
                byte_buf <= {byte_buf[15:0], sd_dout};
                if (byte_cnt[1:0] == 2'd3) begin
                    write_en   <= 1'b1;
                    write_word <= {byte_buf, sd_dout};
                end
            end

            if (state == SECTOR_END && state_next == ISSUE) begin
                sector_cnt <= sector_cnt + 1'b1;
                sd_address <= sd_address + 32'd512;
                sd_rd      <= 1'b1;
            end

            if (state_next == ERROR) sd_rd <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sd_metadata_loader.sv
// Randomized bench: a behavioural SD card model feeds bytes, a byte queue
// predicts every word/index, and literal checks pin the model itself.
module tb_sd_metadata_loader;
    localparam int          NS_A   = 2;
    localparam int          NS_B   = 1;
    localparam int          TO     = 100;
    localparam logic [31:0] BASE_B = 32'h0001_0000;

    logic clk = 1'b0;
    logic reset, start_a, start_b;
    logic sd_ready, sd_ready_m, force_nr, sd_avail;
    logic [7:0] sd_dout;

    logic rd_a, we_a, busy_a, loaded_a, error_a;
    logic [31:0] addr_a, word_a;
    logic [7:0] waddr_a;
    logic rd_b, we_b, busy_b, loaded_b, error_b;
    logic [31:0] addr_b, word_b;
    logic [6:0] waddr_b;

    always #20 clk = ~clk;
    assign sd_ready = sd_ready_m & ~force_nr;

    sd_metadata_loader #(.BASE_ADR(32'h0), .NUM_SECTORS(NS_A), .TIMEOUT(TO)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sd_ready(sd_ready),
        .sd_byte_available(sd_avail), .sd_dout(sd_dout), .sd_rd(rd_a),
        .sd_address(addr_a), .write_en(we_a), .write_word(word_a),
        .write_addr(waddr_a), .busy(busy_a), .loaded(loaded_a), .error(error_a));

    sd_metadata_loader #(.BASE_ADR(BASE_B), .NUM_SECTORS(NS_B), .TIMEOUT(TO)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sd_ready(sd_ready),
        .sd_byte_available(sd_avail), .sd_dout(sd_dout), .sd_rd(rd_b),
        .sd_address(addr_b), .write_en(we_b), .write_word(word_b),
        .write_addr(waddr_b), .busy(busy_b), .loaded(loaded_b), .error(error_b));

    bit sel;  // which DUT the SD model and scoreboard follow
    logic        rd_s, we_s, busy_s, loaded_s, error_s;
    logic [31:0] adr_s, word_s, waddr_s;
    assign rd_s     = sel ? rd_b : rd_a;
    assign we_s     = sel ? we_b : we_a;
    assign busy_s   = sel ? busy_b : busy_a;
    assign loaded_s = sel ? loaded_b : loaded_a;
    assign error_s  = sel ? error_b : error_a;
    assign adr_s    = sel ? addr_b : addr_a;
    assign word_s   = sel ? word_b : word_a;
    assign waddr_s  = sel ? 32'(waddr_b) : 32'(waddr_a);

    int checks = 0, errors = 0;
    int wcount, bytes_sent, to_first;
    int hold_min = 4, hold_max = 4, gap_min = 1, gap_max = 1;
    bit pattern_mode = 1'b1, stall = 1'b0;
    logic [7:0]  pat;
    logic [7:0]  exp_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] cap [0:255];
    logic [31:0] exp_w;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // SD card: accept rd when ready, then stream 512 bytes as level pulses
    initial begin : sd_model
        int h, g;
        sd_ready_m = 1'b1; sd_avail = 1'b0; sd_dout = 8'h00; pat = 8'h00; bytes_sent = 0;
        forever begin
            tick();
            if (!reset && !stall && sd_ready && rd_s) begin
                addr_log.push_back(adr_s);
                sd_ready_m = 1'b0;
                bytes_sent = 0;
                pat = 8'h00;
                for (int c = 0; c < 3 && !reset; c++) tick();
                for (int b = 0; b < 512; b++) begin
                    if (reset) break;
                    sd_dout = pattern_mode ? pat : 8'($urandom);
                    pat = pat + 8'd1;
                    exp_q.push_back(sd_dout);
                    bytes_sent++;
                    sd_avail = 1'b1;
                    h = $urandom_range(hold_max, hold_min);
                    for (int c = 0; c < h && !reset; c++) tick();
                    sd_avail = 1'b0;
                    g = $urandom_range(gap_max, gap_min);
                    for (int c = 0; c < g && !reset; c++) tick();
                end
                for (int c = 0; c < 2 && !reset; c++) tick();
                sd_ready_m = 1'b1;
            end
        end
    end

    // Scoreboard: word k is bytes 4k..4k+3 big-endian at index k mod depth
    always @(negedge clk) begin
        if (!reset) begin
            if (we_s) begin
                if (exp_q.size() < 4) begin
                    checks++; errors++;
                    $display("FAIL write_en_no_bytes got_word=%h pending_bytes=%0d", word_s, exp_q.size());
                end else begin
                    exp_w = {exp_q[0], exp_q[1], exp_q[2], exp_q[3]};
                    repeat (4) void'(exp_q.pop_front());
                    chk("word", word_s, exp_w);
                    chk("waddr", waddr_s, 32'(wcount % ((sel ? NS_B : NS_A) * 128)));
                    if (wcount < 256) cap[wcount] = word_s;
                    wcount++;
                end
            end
            chk("other_dut_quiet", {31'd0, sel ? we_a : we_b}, 32'd0);
            chk("flags_exclusive", {31'd0, loaded_s && (busy_s || error_s)}, 32'd0);
        end
    end

    task automatic pulse_start(input bit which);
        @(negedge clk);
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic run_load(input bit which, input bit poke, input string tag);
        int n;
        logic [31:0] base;
        bit done;
        n = which ? NS_B : NS_A;
        base = which ? BASE_B : 32'h0;
        wcount = 0;
        addr_log.delete();
        pulse_start(which);
        chk({tag, "_busy_after_start"}, {31'd0, busy_s}, 32'd1);
        chk({tag, "_loaded_dropped"}, {31'd0, loaded_s}, 32'd0);
        chk({tag, "_error_clear"}, {31'd0, error_s}, 32'd0);
        done = 1'b0;
        for (int c = 0; c < 40000 && !done; c++) begin
            @(negedge clk);
            start_a = (poke && (c % 500 == 250)) ? 1'b1 : 1'b0;
            if (loaded_s || error_s) done = 1'b1;
        end
        start_a = 1'b0;
        chk({tag, "_loaded"}, {31'd0, loaded_s}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy_s}, 32'd0);
        chk({tag, "_error_end"}, {31'd0, error_s}, 32'd0);
        chk({tag, "_word_count"}, wcount, n * 128);
        chk({tag, "_bytes_left"}, exp_q.size(), 0);
        chk({tag, "_rd_count"}, addr_log.size(), n);
        for (int i = 0; i < addr_log.size(); i++)
            chk({tag, "_sd_address"}, addr_log[i], base + 32'(512 * i));
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; force_nr = 1'b0; sel = 1'b0;
        wcount = 0;
        repeat (3) @(negedge clk);
        chk("rst_rd", {31'd0, rd_a}, 0);
        chk("rst_addr_b", addr_b, BASE_B);
        chk("rst_we", {31'd0, we_a}, 0);
        chk("rst_flags", {29'd0, busy_a, loaded_a, error_a}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Counting pattern, 4-cycle hold
        run_load(0, 0, "pattern");
        chk("pin_word0", cap[0], 32'h00010203);
        chk("pin_word1", cap[1], 32'h04050607);
        chk("pin_word64", cap[64], 32'h00010203);
        chk("pin_word129", cap[129], 32'h04050607);
        chk("waddr_wrapped", {24'd0, waddr_a}, 0);

        // Long level per byte, random data
        pattern_mode = 1'b0;
        hold_min = 10; hold_max = 10; gap_min = 1; gap_max = 3;
        run_load(0, 0, "hold10");

        // Random timing, start pokes while busy (also a restart from DONE)
        hold_min = 1; hold_max = 4;
        run_load(0, 1, "busy_start");

        // sd_ready never comes back
        stall = 1'b1; force_nr = 1'b1;
        wcount = 0; to_first = -1;
        pulse_start(0);
        for (int c = 1; c <= TO + 10; c++) begin
            if (error_a && to_first < 0) to_first = c;
            @(negedge clk);
        end
        checks++;
        if (!(to_first >= TO - 2 && to_first <= TO + 2)) begin
            errors++;
            $display("FAIL timeout_cycle got=%0d required=%0d..%0d", to_first, TO - 2, TO + 2);
        end
        chk("timeout_error", {31'd0, error_a}, 1);
        chk("timeout_rd", {31'd0, rd_a}, 0);
        chk("timeout_no_words", wcount, 0);
        force_nr = 1'b0; stall = 1'b0;
        run_load(0, 0, "from_error");

        // Reset in the middle of sector 0
        wcount = 0; addr_log.delete();
        pulse_start(0);
        for (int c = 0; c < 20000 && !(addr_log.size() == 1 && bytes_sent >= 300); c++) @(negedge clk);
        chk("abort_reached_300", {31'd0, bytes_sent >= 300}, 1);
        @(negedge clk); #3;
        reset = 1'b1; #1;
        chk("abort_rd", {31'd0, rd_a}, 0);
        chk("abort_addr", addr_a, 32'h0);
        chk("abort_we", {31'd0, we_a}, 0);
        chk("abort_word", word_a, 0);
        chk("abort_waddr", {24'd0, waddr_a}, 0);
        chk("abort_flags", {29'd0, busy_a, loaded_a, error_a}, 0);
        repeat (3) @(negedge clk);
        exp_q.delete(); wcount = 0;
        reset = 1'b0;
        @(negedge clk);
        run_load(0, 0, "after_abort");

        // Second instance: non-zero base, single sector
        sel = 1'b1;
        @(negedge clk);
        run_load(1, 0, "base_b");
        chk("b_waddr_wrapped", {25'd0, waddr_b}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_metadata_loader.md
Name: sd_metadata_loader

Overview:
- Sequences the SD card SPI controller (sd_controller) to read NUM_SECTORS consecutive 512-byte sectors starting at BASE_ADR.
- Packs the byte stream into big-endian 32-bit words and pulses each word, with its word index, into the metadata store.
- Asserts loaded when the last word has been delivered; this feeds the game FSM's data_loaded input.
- Runs entirely in the 25 MHz SD clock domain.

Parameters:
- BASE_ADR, 32'h0000_0000, byte address of the first sector; must be a multiple of 512.
- NUM_SECTORS, 8, number of sectors to load; 1..256.
- TIMEOUT, 2_000_000, clk cycles allowed in any wait state before error.

Ports:
- clk  in  1  25 MHz SD clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; ignored while busy.
- sd_ready  in  1  from sd_controller; high when idle and able to accept rd.
- sd_byte_available  in  1  from sd_controller; level, high while sd_dout holds a new byte.
- sd_dout  in  8  read byte from sd_controller.
- sd_rd  out  1  read request to sd_controller.
- sd_address  out  32  sector byte address to sd_controller.
- write_en  out  1  one-cycle pulse; write_word and write_addr are valid.
- write_word  out  32  assembled word; first byte received goes to [31:24].
- write_addr  out  clog2(NUM_SECTORS*128)  word index, counts from 0.
- busy  out  1  high in every state except IDLE, DONE and ERROR.
- loaded  out  1  high in DONE.
- error  out  1  high in ERROR.

Behaviour:
- Reset (async): state=IDLE; sd_rd=0, sd_address=BASE_ADR, write_en=0, write_word=0, write_addr=0, busy=0, loaded=0, error=0. All counters cleared. An abort mid-sector is allowed; the SD controller is reset by the same reset net.
- States: IDLE, WAIT_READY, ISSUE, READ, SECTOR_END, DONE, ERROR.
- IDLE: on start -> WAIT_READY; sector_cnt=0, sd_address=BASE_ADR, write_addr=0.
- DONE and ERROR: start restarts the load exactly as from IDLE, clearing loaded/error on the next edge.
- WAIT_READY: when sd_ready=1 -> ISSUE and sd_rd<=1.
- ISSUE: hold sd_rd=1 until sd_ready samples 0, then sd_rd<=0 -> READ with byte_cnt=0.
- READ:
  - Detect the rising edge of sd_byte_available using a registered copy of it; capture sd_dout on that edge only. A level held for several cycles is one byte.
  - byte_cnt[1:0] selects the byte lane, big-endian.
  - On the capture of lane 3, the next cycle has write_en=1 with the full word. write_addr increments in the cycle after the pulse. write_word holds until the next word completes.
  - After byte 511 -> SECTOR_END.
- SECTOR_END: wait for sd_ready=1.
  - If sector_cnt==NUM_SECTORS-1 -> DONE.
  - Otherwise sector_cnt++, sd_address+=512, -> ISSUE with sd_rd<=1 the same edge.
- Timeout:
  - A counter resets on every state change and on every byte capture.
  - If it reaches TIMEOUT in WAIT_READY, ISSUE, READ or SECTOR_END -> ERROR with sd_rd<=0.
  - Words already written are not retracted.
- Bytes arriving outside READ are ignored. A byte arriving in the same cycle as the 512th capture is impossible by protocol and is not handled.
- Total write_en pulses per successful load = NUM_SECTORS*128, exactly. write_addr ends at NUM_SECTORS*128, wrapping to 0 when that is a power of two (the default).
- Latency: start -> sd_rd high is ≥2 cycles. Last byte capture -> write_en is 1 cycle. loaded rises 1 cycle after sd_ready returns high following the last sector.

Test Plan:
- Reset, NUM_SECTORS=2, SD model returns bytes 0x00..0xFF repeating, each held 4 cycles, start pulse:
  - 256 write_en pulses; word0=0x00010203, word1=0x04050607, word64=0x00010203.
  - write_addr 0..255.
  - sd_address 0x0 then 0x200; loaded=1, busy=0.
- Model holds sd_byte_available high for 10 cycles per byte -> each byte captured once; word count unchanged (128 per sector).
- Model keeps sd_ready=0 after start for TIMEOUT cycles (TIMEOUT=100 in bench) -> error=1 at cycle ~101, sd_rd=0, no write_en.
- Assert reset after byte 300 of sector 0 -> all outputs at reset values within the same cycle. A restart then reloads from word 0 at BASE_ADR.
- start pulses while busy -> ignored, no address restart. Start in DONE -> loaded drops, full reload, loaded rises again.
- BASE_ADR=32'h0001_0000, NUM_SECTORS=1 -> sd_address=0x00010000 on the single sd_rd; 128 pulses; DONE.
